// File: rtl/maze_store.sv
// Cell grid for the wall follower: row-major load, solver read/mark port, row-major dump.
// Optional MAZE_STORE_WALL_PROTECT_EN blocks marks on wall cells and adds a sticky wall_hit.
module maze_store #(
  parameter int unsigned maze_width = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [1:0]              load_data,
  output logic                    load_ready,
  output logic                    maze_ready,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    done,
  output logic                    dump_valid,
  output logic [1:0]              dump_data,
  input  logic                    dump_ready,
  output logic                    dump_last,
  output logic [2*maze_width:0]   path_count
`ifdef MAZE_STORE_WALL_PROTECT_EN
  , output logic                  wall_hit
`endif
);

  localparam int unsigned AW    = 2 * maze_width;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [1:0] CELL_FREE = 2'd0;
  localparam logic [1:0] CELL_WALL = 2'd1;
  localparam logic [1:0] CELL_PATH = 2'd2;
  localparam logic [1:0] CELL_RSVD = 2'd3;
  localparam logic [AW:0] PC_MAX  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DUMP, ST_FIN} state_e;

  logic [1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          load_ready_q, load_ready_d;
  logic          maze_ready_q, maze_ready_d;
  logic          maze_in_q, maze_in_d;
  logic          dump_valid_q, dump_valid_d;
  logic [1:0]    dump_data_q, dump_data_d;
  logic          dump_last_q, dump_last_d;
  logic [AW:0]   path_count_q, path_count_d;
  logic          wall_hit_q, wall_hit_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [1:0]    mem_wdata;
  logic [AW-1:0] cell_addr;
  logic [1:0]    cell_code;
  logic          cell_blocked;
  logic          count_inc;
  logic [AW-1:0] addr_nxt;

  assign cell_addr    = {row, col};
  assign cell_code    = mem[cell_addr];
  assign cell_blocked = (cell_code == CELL_WALL) || (cell_code == CELL_RSVD);
  assign addr_nxt     = addr_q + AW'(1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    load_ready_d = load_ready_q;
    maze_ready_d = maze_ready_q;
    maze_in_d    = maze_in_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
    path_count_d = path_count_q;
    wall_hit_d   = wall_hit_q;
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    mem_wdata    = load_data;
    count_inc    = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = load_data;
          addr_d    = addr_nxt;
          if (&addr_q) begin
            addr_d       = '0;
            state_d      = ST_SERVE;
            load_ready_d = 1'b0;
            maze_ready_d = 1'b1;
          end
        end
      end

      ST_SERVE: begin
        // Read uses the array before this cycle's mark, so oe+we sees the old code.
        if (maze_oe) maze_in_d = cell_blocked;
        if (maze_we) begin
          if (cell_code == CELL_FREE) begin
            mem_we    = 1'b1;
            mem_waddr = cell_addr;
            mem_wdata = CELL_PATH;
            count_inc = 1'b1;
          end else if (cell_blocked) begin
`ifdef MAZE_STORE_WALL_PROTECT_EN
            wall_hit_d = 1'b1;
`else
            mem_we    = 1'b1;
            mem_waddr = cell_addr;
            mem_wdata = CELL_PATH;
            count_inc = 1'b1;
`endif
          end
        end
        if (count_inc && (path_count_q != PC_MAX)) path_count_d = path_count_q + (AW+1)'(1);
        if (done) begin
          state_d      = ST_DUMP;
          maze_ready_d = 1'b0;
        end
      end

      ST_DUMP: begin
        // First DUMP cycle primes the output register so a mark made alongside done is visible.
        if (!dump_valid_q) begin
          dump_valid_d = 1'b1;
          dump_data_d  = mem[addr_q];
          dump_last_d  = &addr_q;
        end else if (dump_ready) begin
          if (dump_last_q) begin
            state_d      = ST_FIN;
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
            dump_data_d  = '0;
            addr_d       = '0;
          end else begin
            addr_d      = addr_nxt;
            dump_data_d = mem[addr_nxt];
            dump_last_d = &addr_nxt;
          end
        end
      end

      ST_FIN: begin
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      addr_q       <= '0;
      load_ready_q <= 1'b1;
      maze_ready_q <= 1'b0;
      maze_in_q    <= 1'b1;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      path_count_q <= '0;
      wall_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      load_ready_q <= load_ready_d;
      maze_ready_q <= maze_ready_d;
      maze_in_q    <= maze_in_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      path_count_q <= path_count_d;
      wall_hit_q   <= wall_hit_d;
    end
  end

  // Cell array has no reset; LOAD rewrites every cell.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign load_ready = load_ready_q;
  assign maze_ready = maze_ready_q;
  assign maze_in    = maze_in_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
  assign path_count = path_count_q;
`ifdef MAZE_STORE_WALL_PROTECT_EN
  assign wall_hit   = wall_hit_q;
`else
  logic unused_wall_hit;
  assign unused_wall_hit = wall_hit_q;
`endif

endmodule

// File: tb/tb_maze_store.sv
// Directed bench for maze_store at maze_width = 2 (16 cells); follows MAZE_STORE_WALL_PROTECT_EN.
module tb_maze_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [1:0] load_data;
  logic       load_ready;
  logic       maze_ready;
  logic [1:0] row, col;
  logic       maze_oe, maze_we;
  logic       maze_in;
  logic       done;
  logic       dump_valid;
  logic [1:0] dump_data;
  logic       dump_ready;
  logic       dump_last;
  logic [4:0] path_count;
`ifdef MAZE_STORE_WALL_PROTECT_EN
  logic       wall_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] grid  [16];
  logic [1:0] model [16];
  int exp_pc;

  maze_store #(.maze_width(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .maze_ready (maze_ready),
    .row        (row),
    .col        (col),
    .maze_oe    (maze_oe),
    .maze_we    (maze_we),
    .maze_in    (maze_in),
    .done       (done),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .dump_last  (dump_last),
    .path_count (path_count)
`ifdef MAZE_STORE_WALL_PROTECT_EN
    , .wall_hit (wall_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!dump_valid && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 32'(dump_valid), 1);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; row = '0; col = '0;
    maze_oe = 1'b0; maze_we = 1'b0; done = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < 16; i++) grid[i] = 2'd0;
    grid[5] = 2'd1; grid[10] = 2'd3; grid[12] = 2'd1;
    for (int i = 0; i < 16; i++) model[i] = grid[i];
    exp_pc = 0;

    tick(); tick();
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_maze_ready", 32'(maze_ready), 0);
    chk("rst_maze_in",    32'(maze_in), 1);
    chk("rst_path_count", 32'(path_count), 0);
    chk("rst_dump_valid", 32'(dump_valid), 0);
    rst = 1'b0;

    // Load with load_valid toggling every other cycle.
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b0;
      tick();
      load_valid = 1'b1;
      load_data  = grid[i];
      if (i == 15) begin
        chk("load_ready_before_last", 32'(load_ready), 1);
        chk("maze_ready_before_last", 32'(maze_ready), 0);
      end
      tick();
    end
    load_valid = 1'b0;
    chk("load_ready_after_load", 32'(load_ready), 0);
    chk("maze_ready_after_load", 32'(maze_ready), 1);
    chk("path_count_after_load", 32'(path_count), 0);

    // Reads: wall, free, hold, reserved.
    maze_oe = 1'b1; row = 2'd1; col = 2'd1; tick();
    chk("rd_wall5", 32'(maze_in), 1);
    row = 2'd1; col = 2'd2; tick();
    chk("rd_free6", 32'(maze_in), 0);
    maze_oe = 1'b0; row = 2'd2; col = 2'd2; tick();
    chk("rd_hold", 32'(maze_in), 0);
    maze_oe = 1'b1; tick();
    chk("rd_rsvd10", 32'(maze_in), 1);

    // oe+we on free cell 1: old code read, count 1; repeat mark does not count.
    row = 2'd0; col = 2'd1; maze_we = 1'b1; tick();
    model[1] = 2'd2; exp_pc = 1;
    chk("oe_we_pre_write", 32'(maze_in), 0);
    chk("mark_count", 32'(path_count), exp_pc);
    tick();
    chk("remark_count", 32'(path_count), exp_pc);
    chk("rd_path1", 32'(maze_in), 0);

    // Mark wall cell 5 then read it back.
    maze_oe = 1'b0; row = 2'd1; col = 2'd1; tick();
    maze_we = 1'b0; maze_oe = 1'b1; tick();
    maze_oe = 1'b0;
`ifdef MAZE_STORE_WALL_PROTECT_EN
    chk("wall_kept", 32'(maze_in), 1);
    chk("wall_hit", 32'(wall_hit), 1);
`else
    model[5] = 2'd2; exp_pc++;
    chk("wall_overwritten", 32'(maze_in), 0);
`endif
    chk("wall_mark_count", 32'(path_count), exp_pc);

    // done with a mark on cell 0 in the same cycle.
    row = 2'd0; col = 2'd0; maze_we = 1'b1; done = 1'b1; tick();
    maze_we = 1'b0; done = 1'b0;
    model[0] = 2'd2; exp_pc++;
    chk("done_mark_count", 32'(path_count), exp_pc);
    chk("maze_ready_after_done", 32'(maze_ready), 0);

    // Stall three cycles, then drain.
    wait_valid("dump_first_timeout");
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", 32'(dump_valid), 1);
      chk("stall_data", 32'(dump_data), 32'(model[0]));
      tick();
    end
    dump_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_valid("dump_beat_timeout");
      chk($sformatf("dump_data_%0d", i), 32'(dump_data), 32'(model[i]));
      chk($sformatf("dump_last_%0d", i), 32'(dump_last), (i == 15) ? 1 : 0);
      tick();
    end
    chk("fin_dump_valid", 32'(dump_valid), 0);
    chk("fin_dump_last", 32'(dump_last), 0);
    tick(); tick();
    chk("fin_idle_valid", 32'(dump_valid), 0);
    chk("fin_path_count", 32'(path_count), exp_pc);

    // Second pass: reset in the middle of the dump.
    dump_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_data = grid[i];
      tick();
    end
    load_valid = 1'b0;
    chk("reload_maze_ready", 32'(maze_ready), 1);
    maze_oe = 1'b1; maze_we = 1'b1; row = 2'd0; col = 2'd1; tick();
    maze_oe = 1'b0; maze_we = 1'b0;
    chk("reload_mark_count", 32'(path_count), 1);
    chk("reload_maze_in", 32'(maze_in), 0);
    done = 1'b1; tick(); done = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid("dump2_beat_timeout");
      tick();
    end
    wait_valid("dump2_beat7_timeout");
    chk("dump2_beat7_data", 32'(dump_data), 32'(grid[7]));
    rst = 1'b1; tick(); rst = 1'b0; dump_ready = 1'b0;
    chk("abort_load_ready", 32'(load_ready), 1);
    chk("abort_dump_valid", 32'(dump_valid), 0);
    chk("abort_path_count", 32'(path_count), 0);
    chk("abort_maze_in",    32'(maze_in), 1);
    chk("abort_maze_ready", 32'(maze_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
